// File: rtl/multiply3_pkg.sv
// Shared types and fixed widths for the multiply3 arbiter slice.
// The operand/product widths are set by the multiply3 datapath itself.
package multiply3_pkg;

    localparam int A_W = 2;
    localparam int P_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        RESULT
    } arb_state_t;

endpackage

// File: rtl/multiply3.sv
// Combinational times-three unit: product = a * 3, built as (a << 1) + a.
module multiply3
#(
    parameter int A_W = 2,
    parameter int P_W = 4
)(
    input  logic [A_W-1:0] a_i,
    output logic [P_W-1:0] p_o
);

    assign p_o = P_W'(a_i) + P_W'({a_i, 1'b0});

endmodule

// File: rtl/multiply3_arbiter.sv
// Round-robin arbiter that shares one multiply3 unit between two requesters
// and holds each product on a valid/ready result port until it is consumed.
module multiply3_arbiter
    import multiply3_pkg::*;
#(
    parameter int A_W   = multiply3_pkg::A_W,
    parameter int P_W   = multiply3_pkg::P_W,
    parameter int CNT_W = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [A_W-1:0]   a0,
    input  logic [A_W-1:0]   a1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [P_W-1:0]   res,
    output logic             res_id,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    arb_state_t       state_q, state_d;
    logic [A_W-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic [P_W-1:0]   res_q, res_d;
    logic             res_id_q, res_id_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;
    logic             gnt0_q, gnt1_q, res_valid_q, busy_q;
    logic             winner;
    logic [P_W-1:0]   product;

    multiply3 #(
        .A_W (A_W),
        .P_W (P_W)
    ) u_multiply3 (
        .a_i (op_q),
        .p_o (product)
    );

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        res_d        = res_q;
        res_id_d     = res_id_q;
        done_count_d = done_count_q;
        winner       = (req0 && req1) ? ~last_grant_q : req1;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = COMPUTE;
                    id_d    = winner;
                    op_d    = winner ? a1 : a0;
                end
            end
            COMPUTE: begin
                res_d        = product;
                res_id_d     = id_q;
                last_grant_d = id_q;
                state_d      = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flag outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            res_q        <= '0;
            res_id_q     <= 1'b0;
            done_count_q <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            res_q        <= res_d;
            res_id_q     <= res_id_d;
            done_count_q <= done_count_d;
            gnt0_q       <= (state_d == COMPUTE) && !id_d;
            gnt1_q       <= (state_d == COMPUTE) && id_d;
            res_valid_q  <= (state_d == RESULT);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign res_valid  = res_valid_q;
    assign res        = res_q;
    assign res_id     = res_id_q;
    assign busy       = busy_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_multiply3_arbiter.sv
// Directed plus randomized bench for multiply3_arbiter against a
// transaction-level model of round-robin arbitration and the times-three product.
module tb_multiply3_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] a0 = '0, a1 = '0;
    logic       res_ready = 1'b0;
    logic       gnt0, gnt1, res_valid, res_id, busy;
    logic [3:0] res;
    logic [7:0] done_count;

    int compared = 0;
    int mismatched = 0;
    int mLast = 1;
    int mDone = 0;

    multiply3_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .a0         (a0),
        .a1         (a1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res        (res),
        .res_id     (res_id),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".gnt0"}, 32'(gnt0), 0);
        checkOutput({tag, ".gnt1"}, 32'(gnt1), 0);
        checkOutput({tag, ".valid"}, 32'(res_valid), 0);
        checkOutput({tag, ".res"}, 32'(res), 0);
        checkOutput({tag, ".id"}, 32'(res_id), 0);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".done"}, 32'(done_count), 0);
    endtask

    // One transaction from IDLE; the model picks the winner from req pattern and last grant.
    task automatic applyStimulus(input bit r0, input bit r1, input logic [1:0] v0,
                                 input logic [1:0] v1, input int readyDelay, input bit lateReq1);
        int winner;
        int expRes;
        req0 = r0;
        req1 = r1;
        a0 = v0;
        a1 = v1;
        res_ready = (readyDelay == 0);
        winner = (r0 && r1) ? 1 - mLast : (r1 ? 1 : 0);
        expRes = (winner == 1 ? int'(v1) : int'(v0)) * 3;

        step();
        checkOutput("compute.gnt0", 32'(gnt0), 32'(winner == 0));
        checkOutput("compute.gnt1", 32'(gnt1), 32'(winner == 1));
        checkOutput("compute.busy", 32'(busy), 1);
        checkOutput("compute.valid", 32'(res_valid), 0);

        step();
        mLast = winner;
        checkOutput("result.valid", 32'(res_valid), 1);
        checkOutput("result.res", 32'(res), 32'(expRes));
        checkOutput("result.id", 32'(res_id), 32'(winner));
        checkOutput("result.gnt", 32'({gnt0, gnt1}), 0);

        for (int i = 0; i < readyDelay; i++) begin
            res_ready = 1'b0;
            req0 = 1'b0;
            req1 = lateReq1;
            step();
            checkOutput("hold.valid", 32'(res_valid), 1);
            checkOutput("hold.res", 32'(res), 32'(expRes));
            checkOutput("hold.id", 32'(res_id), 32'(winner));
            checkOutput("hold.gnt", 32'({gnt0, gnt1}), 0);
            checkOutput("hold.done", 32'(done_count), 32'(mDone));
        end

        res_ready = 1'b1;
        step();
        mDone = (mDone + 1) % 256;
        checkOutput("idle.done", 32'(done_count), 32'(mDone));
        checkOutput("idle.valid", 32'(res_valid), 0);
        checkOutput("idle.busy", 32'(busy), 0);
    endtask

    initial begin
        // Reset with random inputs applied
        for (int i = 0; i < 3; i++) begin
            req0 = 1'($urandom);
            req1 = 1'($urandom);
            a0 = 2'($urandom);
            a1 = 2'($urandom);
            res_ready = 1'($urandom);
            step();
            checkResetOutputs("reset");
        end
        req0 = 1'b0;
        req1 = 1'b0;
        #2 reset = 1'b0;
        step();
        checkResetOutputs("postreset");

        // Single request from requester 0 with maximum operand
        applyStimulus(1, 0, 2'b11, 2'b00, 0, 0);

        // Tie with both requests held: alternating winners
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 2'd1, 2'd2, 0, 0);

        // Backpressure with requester 1 waiting, then it is granted
        applyStimulus(1, 0, 2'd2, 2'd3, 5, 1);
        applyStimulus(0, 1, 2'd0, 2'd3, 0, 0);

        // Reset during COMPUTE drops the transaction
        req0 = 1'b1;
        req1 = 1'b1;
        a0 = 2'd3;
        a1 = 2'd3;
        step();
        checkOutput("midreset.gntseen", 32'(gnt0 | gnt1), 1);
        reset = 1'b1;
        #1;
        checkResetOutputs("midreset");
        req0 = 1'b0;
        req1 = 1'b0;
        #1 reset = 1'b0;
        mLast = 1;
        mDone = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("midreset.novalid", 32'(res_valid), 0);
            checkOutput("midreset.done", 32'(done_count), 0);
        end
        applyStimulus(1, 1, 2'd1, 2'd2, 0, 0);

        // Randomized traffic long enough to wrap the completion counter
        for (int i = 0; i < 260; i++) begin
            int pattern;
            pattern = int'($urandom_range(1, 3));
            applyStimulus(pattern[0], pattern[1], 2'($urandom), 2'($urandom),
                          ($urandom_range(0, 7) == 0) ? 2 : 0, 1'($urandom));
        end
        checkOutput("wrap.done", 32'(done_count), 32'(mDone));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
